// File: rtl/reset_sequencer.sv
// Ordered reset release for NUM_DOMAINS downstream domains with ack handshake and guard gaps.
// Optional acknowledge watchdog enabled by defining RESET_SEQ_TIMEOUT_EN.
module reset_sequencer #(
    parameter int unsigned NUM_DOMAINS    = 4,
    parameter int unsigned HOLD_CYCLES    = 16,
    parameter int unsigned GAP_CYCLES     = 8,
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic                                                 clk,
    input  logic                                                 reset,
    input  logic                                                 sw_reset_req,
    input  logic [NUM_DOMAINS-1:0]                               domain_ack,
    output logic [NUM_DOMAINS-1:0]                               domain_reset,
    output logic                                                 all_ready,
    output logic                                                 busy,
    output logic                                                 fault,
    output logic [((NUM_DOMAINS > 2) ? $clog2(NUM_DOMAINS) : 1)-1:0] fault_domain
);

    localparam int unsigned IdxW   = (NUM_DOMAINS > 2) ? $clog2(NUM_DOMAINS) : 1;
    localparam int unsigned MaxHg  = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
    localparam int unsigned MaxCnt = (MaxHg > TIMEOUT_CYCLES) ? MaxHg : TIMEOUT_CYCLES;
    localparam int unsigned CntW   = (MaxCnt > 1) ? $clog2(MaxCnt) : 1;
    localparam logic [IdxW-1:0] LastIdx = IdxW'(NUM_DOMAINS - 1);

`ifdef RESET_SEQ_TIMEOUT_EN
    typedef enum logic [2:0] {StHold, StWaitAck, StGap, StDone, StFault} state_e;
`else
    typedef enum logic [1:0] {StHold, StWaitAck, StGap, StDone} state_e;
`endif

    state_e                 state_q, state_d;
    logic [CntW-1:0]        cnt_q, cnt_d;
    logic [IdxW-1:0]        idx_q, idx_d, idx_next;
    logic [NUM_DOMAINS-1:0] dom_rst_q, dom_rst_d;
    logic                   all_ready_q, all_ready_d;
    logic                   busy_q, busy_d;
`ifdef RESET_SEQ_TIMEOUT_EN
    logic                   fault_q, fault_d;
    logic [IdxW-1:0]        fault_idx_q, fault_idx_d;
`endif

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        idx_d       = idx_q;
        idx_next    = idx_q + IdxW'(1);
        dom_rst_d   = dom_rst_q;
        all_ready_d = all_ready_q;
        busy_d      = busy_q;
`ifdef RESET_SEQ_TIMEOUT_EN
        fault_d     = fault_q;
        fault_idx_d = fault_idx_q;
`endif
        if (sw_reset_req) begin
            state_d     = StHold;
            cnt_d       = '0;
            idx_d       = '0;
            dom_rst_d   = '1;
            all_ready_d = 1'b0;
            busy_d      = 1'b1;
`ifdef RESET_SEQ_TIMEOUT_EN
            fault_d     = 1'b0;
`endif
        end else begin
            unique case (state_q)
                StHold: begin
                    if (cnt_q == CntW'(HOLD_CYCLES - 1)) begin
                        dom_rst_d[0] = 1'b0;
                        cnt_d        = '0;
                        state_d      = StWaitAck;
                    end else begin
                        cnt_d = cnt_q + CntW'(1);
                    end
                end
                StWaitAck: begin
                    if (domain_ack[idx_q]) begin
                        if (idx_q == LastIdx) begin
                            state_d     = StDone;
                            all_ready_d = 1'b1;
                            busy_d      = 1'b0;
                        end else begin
                            state_d = StGap;
                            cnt_d   = '0;
                        end
                    end else begin
`ifdef RESET_SEQ_TIMEOUT_EN
                        // Ack on the timeout edge itself is taken above and wins.
                        if (cnt_q == CntW'(TIMEOUT_CYCLES - 1)) begin
                            state_d     = StFault;
                            fault_d     = 1'b1;
                            fault_idx_d = idx_q;
                            dom_rst_d   = '1;
                            busy_d      = 1'b0;
                            all_ready_d = 1'b0;
                        end else
`endif
                        cnt_d = cnt_q + CntW'(1);
                    end
                end
                StGap: begin
                    if (cnt_q == CntW'(GAP_CYCLES - 1)) begin
                        idx_d               = idx_next;
                        dom_rst_d[idx_next] = 1'b0;
                        cnt_d               = '0;
                        state_d             = StWaitAck;
                    end else begin
                        cnt_d = cnt_q + CntW'(1);
                    end
                end
                StDone: begin
                end
`ifdef RESET_SEQ_TIMEOUT_EN
                StFault: begin
                end
`endif
                default: state_d = StHold;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= StHold;
            cnt_q       <= '0;
            idx_q       <= '0;
            dom_rst_q   <= '1;
            all_ready_q <= 1'b0;
            busy_q      <= 1'b1;
`ifdef RESET_SEQ_TIMEOUT_EN
            fault_q     <= 1'b0;
            fault_idx_q <= '0;
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            dom_rst_q   <= dom_rst_d;
            all_ready_q <= all_ready_d;
            busy_q      <= busy_d;
`ifdef RESET_SEQ_TIMEOUT_EN
            fault_q     <= fault_d;
            fault_idx_q <= fault_idx_d;
`endif
        end
    end

    assign domain_reset = dom_rst_q;
    assign all_ready    = all_ready_q;
    assign busy         = busy_q;
`ifdef RESET_SEQ_TIMEOUT_EN
    assign fault        = fault_q;
    assign fault_domain = fault_idx_q;
`else
    assign fault        = 1'b0;
    assign fault_domain = '0;
`endif

endmodule

// File: tb/tb_reset_sequencer.sv
// Bench for reset_sequencer: randomized acknowledge timing checked against a timeline model.
// Timeout scenarios are built only when RESET_SEQ_TIMEOUT_EN is defined.
module tb_reset_sequencer;

    localparam int N     = 4;
    localparam int H     = 16;
    localparam int G     = 8;
    localparam int T     = 1024;
    localparam int IdxW  = 2;
    localparam int NEVER = 32'h3fff_ffff;

    logic            clk;
    logic            reset;
    logic            sw_reset_req;
    logic [N-1:0]    domain_ack;
    logic [N-1:0]    domain_reset;
    logic            all_ready;
    logic            busy;
    logic            fault;
    logic [IdxW-1:0] fault_domain;

    reset_sequencer #(
        .NUM_DOMAINS    (N),
        .HOLD_CYCLES    (H),
        .GAP_CYCLES     (G),
        .TIMEOUT_CYCLES (T)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .sw_reset_req (sw_reset_req),
        .domain_ack   (domain_ack),
        .domain_reset (domain_reset),
        .all_ready    (all_ready),
        .busy         (busy),
        .fault        (fault),
        .fault_domain (fault_domain)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cur_e  = 0;

    // Timeline model: absolute edge numbers of each release, ack arrival, completion, fault.
    int rel   [N];
    int ackat [N];
    int done_e, fault_e, fault_idx;
    bit force_high;
    int slow_dom, slow_delay;

    function automatic void build(input int origin);
        int k;
        int a;
        done_e  = NEVER;
        fault_e = NEVER;
        fault_idx = 0;
        for (int i = 0; i < N; i++) begin
            rel[i]   = NEVER;
            ackat[i] = NEVER;
        end
        rel[0] = origin + H;
        for (int i = 0; i < N; i++) begin
            if (force_high) a = origin + 1;
            else if (i == slow_dom) a = rel[i] + slow_delay;
            else a = rel[i] - 20 + int'($urandom_range(0, 40));
            if (a < origin + 1) a = origin + 1;
            ackat[i] = a;
            k = (a > rel[i] + 1) ? a : rel[i] + 1;
`ifdef RESET_SEQ_TIMEOUT_EN
            if (k > rel[i] + T) begin
                fault_e   = rel[i] + T;
                fault_idx = i;
                break;
            end
`endif
            if (i == N - 1) done_e = k;
            else rel[i+1] = k + G;
        end
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s at edge %0d: got %0h expected %0h", tag, cur_e, obs, exp);
        end
    endtask

    task automatic check_outputs(input int e);
        logic [N-1:0] exp_dr;
        bit faulted;
        faulted = (e >= fault_e);
        for (int i = 0; i < N; i++) exp_dr[i] = faulted ? 1'b1 : (e < rel[i]);
        chk("domain_reset", 32'(domain_reset), 32'(exp_dr));
        chk("all_ready", 32'(all_ready), 32'((e >= done_e) && !faulted));
        chk("busy", 32'(busy), 32'(!(e >= done_e) && !faulted));
        chk("fault", 32'(fault), 32'(faulted));
        if (faulted) chk("fault_domain", 32'(fault_domain), 32'(fault_idx));
`ifndef RESET_SEQ_TIMEOUT_EN
        chk("fault_domain_tied", 32'(fault_domain), 32'd0);
`endif
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset        = 1'b1;
        sw_reset_req = 1'b0;
        domain_ack   = '0;
        @(posedge clk);
        #1;
        cur_e = 0;
        chk("rst_domain_reset", 32'(domain_reset), 32'hf);
        chk("rst_all_ready", 32'(all_ready), 32'd0);
        chk("rst_busy", 32'(busy), 32'd1);
        chk("rst_fault", 32'(fault), 32'd0);
        chk("rst_fault_domain", 32'(fault_domain), 32'd0);
    endtask

    // Edge 1 is the first posedge after do_reset; sw/rst pulses restart the timeline there.
    task automatic run(input int ncyc, input int sw_at, input int rst_at);
        for (int e = 1; e <= ncyc; e++) begin
            @(negedge clk);
            reset        = (e == rst_at);
            sw_reset_req = (e == sw_at);
            for (int i = 0; i < N; i++) domain_ack[i] = (e >= ackat[i]);
            @(posedge clk);
            #1;
            cur_e = e;
            if (e == sw_at || e == rst_at) build(e);
            check_outputs(e);
        end
        @(negedge clk);
        reset        = 1'b0;
        sw_reset_req = 1'b0;
    endtask

    initial begin
        int sw_at;
        reset        = 1'b1;
        sw_reset_req = 1'b0;
        domain_ack   = '0;
        slow_dom     = -1;
        slow_delay   = 0;

        // Nominal, acks tied high, then reset while in DONE and repeat.
        force_high = 1'b1;
        do_reset();
        build(0);
        run(130, 0, 70);

        // Randomized ack timing, every other run interrupted by a software request.
        force_high = 1'b0;
        for (int r = 0; r < 6; r++) begin
            do_reset();
            build(0);
            sw_at = (r % 2 == 1) ? int'($urandom_range(2, done_e + 5)) : 0;
            run(260, sw_at, 0);
        end

        // Slow acknowledge on domain 1.
        slow_dom   = 1;
        slow_delay = 50;
        do_reset();
        build(0);
        run(done_e + 10, 0, 0);

        // Software re-sequence while waiting on domain 2.
        slow_dom   = 2;
        slow_delay = 10;
        do_reset();
        build(0);
        sw_at = rel[2] + 3;
        run(sw_at + 200, sw_at, 0);

`ifdef RESET_SEQ_TIMEOUT_EN
        // Ack on the timeout edge wins; one edge later faults.
        slow_dom   = 1;
        slow_delay = T;
        do_reset();
        build(0);
        run(done_e + 10, 0, 0);

        slow_delay = T + 1;
        do_reset();
        build(0);
        run(fault_e + 10, 0, 0);

        // Ack never arrives: fault, then software request clears it and restarts.
        slow_delay = NEVER / 2;
        do_reset();
        build(0);
        sw_at = fault_e + 5;
        run(sw_at + 60, sw_at, 0);
`else
        // No watchdog: long stall on domain 1, then the ack completes the sequence.
        slow_dom   = 1;
        slow_delay = 5000;
        do_reset();
        build(0);
        run(done_e + 10, 0, 0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/reset_sequencer.md
# reset_sequencer

Sequences the release of `NUM_DOMAINS` downstream reset domains in a fixed order: domain 0 first, domain `NUM_DOMAINS-1` last. Each domain waits for the previous domain's ready acknowledge plus a guard gap before its reset is released. The block sits directly behind `reset_synchronizer`, whose `reset_sync` output drives this block's `reset`. It provides a software-triggered full re-sequence and an optional acknowledge-timeout fault.

## Interface
- `NUM_DOMAINS`, 4: number of sequenced domains; must be ≥2.
- `HOLD_CYCLES`, 16: cycles all domains are held in reset before domain 0 is released; must be ≥1.
- `GAP_CYCLES`, 8: guard cycles between an acknowledge and release of the next domain; must be ≥1.
- `TIMEOUT_CYCLES`, 1024: acknowledge watchdog limit, used only with the macro; must be ≥1.
- `clk`  in  1  sole clock.
- `reset`  in  1  synchronous, active-high reset.
- `sw_reset_req`  in  1  one-cycle request to restart the whole sequence.
- `domain_ack`  in  `NUM_DOMAINS`  bit i high = domain i is out of reset and ready.
- `domain_reset`  out  `NUM_DOMAINS`  active-high reset for domain i, registered.
- `all_ready`  out  1  all domains released and acknowledged.
- `busy`  out  1  a sequence is in progress.
- `fault`  out  1  acknowledge timeout occurred.
- `fault_domain`  out  `max(1,$clog2(NUM_DOMAINS))`  index of the domain that timed out.

## Operation
- States: HOLD, WAIT_ACK, GAP, DONE, FAULT.
- Index register `idx`: width `max(1,$clog2(NUM_DOMAINS))`.
- Counter `cnt`: wide enough for `max(HOLD_CYCLES, GAP_CYCLES, TIMEOUT_CYCLES)`.
- Reset values: state=HOLD, `cnt`=0, `idx`=0, `domain_reset`=all ones, `all_ready`=0, `busy`=1, `fault`=0, `fault_domain`=0.
- HOLD:
  - `cnt` increments each edge.
  - On the edge where `cnt==HOLD_CYCLES-1`: clear `domain_reset[0]`, set `cnt`=0, go to WAIT_ACK.
- WAIT_ACK:
  - Sample `domain_ack[idx]`. If it is high and `idx==NUM_DOMAINS-1`: go to DONE, set `all_ready`=1, `busy`=0.
  - If it is high and `idx` is not the last domain: go to GAP with `cnt`=0.
  - Otherwise `cnt` increments (used only by the timeout).
- GAP:
  - `cnt` increments each edge.
  - On the edge where `cnt==GAP_CYCLES-1`: `idx`++, clear `domain_reset[idx+1]`, set `cnt`=0, go to WAIT_ACK.
- DONE: hold all outputs. Ignore `domain_ack`.
- FAULT: see Configuration.
- Released domains stay released. Acknowledges of domains other than `idx` are ignored. A later drop of an acknowledge is not monitored.
- `sw_reset_req` is accepted in every state:
  - Effect on the next edge: all `domain_reset` bits high, `all_ready`=0, `busy`=1, `fault`=0, state=HOLD, `cnt`=0, `idx`=0.
  - A request arriving during HOLD restarts the hold count.
- Priority: `reset` > `sw_reset_req` > timeout > normal sequencing.

## Timing
- Edge numbering: edge 1 is the first rising edge with `reset` low. Outputs change after the edge that causes them.
- `domain_reset[0]` falls after edge `HOLD_CYCLES`.
- An acknowledge sampled at edge k in WAIT_ACK releases the next domain after edge k+`GAP_CYCLES`.
- Acknowledge already high at release: accepted on the first edge after release (one-cycle minimum in WAIT_ACK).
- `all_ready` rises after the edge that samples the last domain's acknowledge.
- `reset` or `sw_reset_req` mid-sequence: every `domain_reset` bit is re-asserted after that same edge. Partially released domains have no per-domain ordering.

## Configuration
- Macro `RESET_SEQ_TIMEOUT_EN`.
- Defined:
  - Timeout trigger: WAIT_ACK is entered at release edge R. If there is no acknowledge through edge R+`TIMEOUT_CYCLES` (i.e. `cnt==TIMEOUT_CYCLES-1` without ack), the block enters FAULT after that edge.
  - If the acknowledge arrives on the timeout edge, the acknowledge wins.
  - FAULT outputs: `fault`=1, `fault_domain`=`idx`, all `domain_reset` re-asserted, `busy`=0, `all_ready`=0.
  - FAULT is held until `reset` or `sw_reset_req`.
- Undefined: WAIT_ACK waits indefinitely. `fault` and `fault_domain` are tied 0 and no FAULT state is built.

## Test plan
- Nominal sequence (defaults, `domain_ack` tied high, `reset` low from edge 1):
  - `domain_reset[0]` falls after edge 16, [1] after 25, [2] after 34, [3] after 43.
  - `all_ready`=1 and `busy`=0 after edge 44.
- Slow acknowledge: `domain_ack[1]` rises 50 cycles after `domain_reset[1]` falls, sampled at edge k → `domain_reset[2]` falls after edge k+8 and no earlier.
- Software re-sequence: pulse `sw_reset_req` while in WAIT_ACK for domain 2 → all `domain_reset` high after that edge, `all_ready`=0, `busy`=1; `domain_reset[0]` falls 16 edges later.
- Timeout, macro defined, `TIMEOUT_CYCLES`=1024:
  - Hold `domain_ack[1]` low → after release edge R+1024, `fault`=1, `fault_domain`=1, `domain_reset`=4'b1111.
  - Then pulse `sw_reset_req` → `fault`=0 and the sequence restarts.
- Reset in DONE: assert `reset` for 1 cycle → after that edge, `domain_reset`=4'b1111, `all_ready`=0, `busy`=1; the full sequence repeats with nominal timing.
- No timeout, macro undefined: hold `domain_ack[1]` low for 5000 cycles → `fault` stays 0 and the state stays WAIT_ACK; then assert the ack → `domain_reset[2]` falls 8 edges after it is sampled.
